// File: rtl/rom_read_arbiter.sv
// Two-requester round-robin arbiter in front of a synchronous-read ROM.
// Serialises reads, waits out the memory latency, then returns the captured
// word to the winning requester with a one-cycle valid pulse.
module rom_read_arbiter #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iReq0,
    input  logic [ADDR_W-1:0] iAddr0,
    input  logic              iReq1,
    input  logic [ADDR_W-1:0] iAddr1,
    output logic              oGnt0,
    output logic              oGnt1,
    output logic              oValid0,
    output logic              oValid1,
    output logic [DATA_W-1:0] oData,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic              oMemEn,
    input  logic [DATA_W-1:0] iMemData,
    output logic              oBusy
);

    // Counter wide enough for MEM_LAT-1 over the legal 1..4 range.
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic                win_q,   win_d;
    logic                last_q,  last_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [DATA_W-1:0]   data_q,  data_d;

    logic                req_any;
    logic                pick;

    // With both requesting, the one that did not win last time goes first;
    // otherwise the lone requester wins.
    assign req_any = iReq0 | iReq1;
    assign pick    = (iReq0 & iReq1) ? ~last_q : iReq1;

    // State register; reset returns to IDLE and drops any in-flight read.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values: arbitration, latency count, capture.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        win_d   = win_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = ISSUE;
                    win_d   = pick;
                    last_d  = pick;
                    addr_d  = pick ? iAddr1 : iAddr0;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    data_d  = iMemData;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers; rLast resets to 1 so requester 0 has first priority.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            addr_q <= '0;
            win_q  <= 1'b0;
            last_q <= 1'b1;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            addr_q <= addr_d;
            win_q  <= win_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    // Outputs decoded from state and registered winner only; no path from iReq.
    always_comb begin
        oMemEn  = (state_q == ISSUE);
        oGnt0   = (state_q == ISSUE) & ~win_q;
        oGnt1   = (state_q == ISSUE) &  win_q;
        oValid0 = (state_q == RESP)  & ~win_q;
        oValid1 = (state_q == RESP)  &  win_q;
        oBusy   = (state_q != IDLE);
    end

    assign oMemAddr = addr_q;
    assign oData    = data_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each with
// a ROM model, checked every cycle against a transaction-timeline model.
module tb_rom_read_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic       clk;
    logic       rst;
    logic       req0  [2];
    logic [1:0] addr0 [2];
    logic       req1  [2];
    logic [1:0] addr1 [2];
    logic       gnt0  [2];
    logic       gnt1  [2];
    logic       val0  [2];
    logic       val1  [2];
    logic [7:0] data  [2];
    logic [1:0] maddr [2];
    logic       men   [2];
    logic [7:0] mdata [2];
    logic       busy  [2];

    logic [7:0] rom [4];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;
    int cyc      = 0;

    rom_read_arbiter #(.ADDR_W(2), .DATA_W(8), .MEM_LAT(LAT0)) u_lat1 (
        .iClk(clk), .iReset(rst),
        .iReq0(req0[0]), .iAddr0(addr0[0]), .iReq1(req1[0]), .iAddr1(addr1[0]),
        .oGnt0(gnt0[0]), .oGnt1(gnt1[0]), .oValid0(val0[0]), .oValid1(val1[0]),
        .oData(data[0]), .oMemAddr(maddr[0]), .oMemEn(men[0]),
        .iMemData(mdata[0]), .oBusy(busy[0])
    );

    rom_read_arbiter #(.ADDR_W(2), .DATA_W(8), .MEM_LAT(LAT1)) u_lat3 (
        .iClk(clk), .iReset(rst),
        .iReq0(req0[1]), .iAddr0(addr0[1]), .iReq1(req1[1]), .iAddr1(addr1[1]),
        .oGnt0(gnt0[1]), .oGnt1(gnt1[1]), .oValid0(val0[1]), .oValid1(val1[1]),
        .oData(data[1]), .oMemAddr(maddr[1]), .oMemEn(men[1]),
        .iMemData(mdata[1]), .oBusy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM models: a chain of LAT registers; 0xEE appears when not enabled.
    logic [7:0] mA, mB0, mB1, mB2;
    always @(posedge clk) begin
        mA  <= men[0] ? rom[maddr[0]] : 8'hEE;
        mB0 <= men[1] ? rom[maddr[1]] : 8'hEE;
        mB1 <= mB0;
        mB2 <= mB1;
    end
    assign mdata[0] = mA;
    assign mdata[1] = mB2;

    // Timeline model: an access granted at edge g occupies cycles g..g+LAT+1,
    // gets data at g+LAT+1 and the next arbitration happens at edge g+LAT+3.
    int         m_g    [2];
    int         m_win  [2];
    int         m_last [2];
    logic [1:0] m_addr [2];
    logic [7:0] m_data [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_g[i]    = -100;
                m_win[i]  = 0;
                m_last[i] = 1;
                m_addr[i] = 2'd0;
                m_data[i] = 8'h00;
            end else begin
                if (cyc == m_g[i] + 1 + lat_of(i))
                    m_data[i] = rom[m_addr[i]];
                if (cyc >= m_g[i] + 3 + lat_of(i) && (req0[i] || req1[i])) begin
                    if (req0[i] && req1[i]) m_win[i] = (m_last[i] == 0) ? 1 : 0;
                    else                    m_win[i] = req1[i] ? 1 : 0;
                    m_last[i] = m_win[i];
                    m_addr[i] = (m_win[i] == 1) ? addr1[i] : addr0[i];
                    m_g[i]    = cyc;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison of all outputs of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [15:0] act, exp;
                logic        eg, ev, eb;
                eg  = (cyc == m_g[i]);
                ev  = (cyc == m_g[i] + 1 + lat_of(i));
                eb  = (cyc >= m_g[i]) && (cyc <= m_g[i] + 1 + lat_of(i));
                exp = {eg && (m_win[i] == 0), eg && (m_win[i] == 1),
                       ev && (m_win[i] == 0), ev && (m_win[i] == 1),
                       eg, eb, m_addr[i], m_data[i]};
                act = {gnt0[i], gnt1[i], val0[i], val1[i], men[i], busy[i], maddr[i], data[i]};
                chk($sformatf("cycle%0d_inst%0d {gnt0,gnt1,v0,v1,en,busy,addr,data}", cyc, i),
                    {16'h0, act}, {16'h0, exp});
            end
        end
    end

    // Log of valid pulses on the MEM_LAT=1 instance: {requester, data}.
    logic [8:0] vlog [$];
    always @(negedge clk) begin
        if (chk_en) begin
            if (val0[0]) vlog.push_back({1'b0, data[0]});
            if (val1[0]) vlog.push_back({1'b1, data[0]});
        end
    end

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt1(input int inst, output int n, output bit ok);
        ok = 0;
        n  = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n = n + 1;
            if (gnt1[inst]) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, vc, nb;
        bit ok;
        logic [7:0] vd;
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req0[i] = 1'b0; req1[i] = 1'b0; addr0[i] = 2'd0; addr1[i] = 2'd0;
        end
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("reset_outputs_inst0", {gnt0[0], gnt1[0], val0[0], val1[0], men[0], busy[0], maddr[0], data[0]}, 0);
        rst = 1'b0;

        // Single read, requester 0, address 2.
        req0[0] = 1'b1; addr0[0] = 2'd2;
        @(negedge clk);
        req0[0] = 1'b0;
        chk("t1_gnt0", gnt0[0], 1);
        chk("t1_memen", men[0], 1);
        chk("t1_memaddr", maddr[0], 2);
        chk("t1_gnt1", gnt1[0], 0);
        drain(2);
        chk("t1_valid0", val0[0], 1);
        chk("t1_data", data[0], 8'h33);
        chk("t1_valid1", val1[0], 0);
        @(negedge clk);
        chk("t1_idle_busy", busy[0], 0);

        // Fresh reset, then both requesting continuously.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vlog.delete();
        req0[0] = 1'b1; addr0[0] = 2'd0; req1[0] = 1'b1; addr1[0] = 2'd3;
        drain(16);
        req0[0] = 1'b0; req1[0] = 1'b0;
        drain(4);
        chk("t2_nvalid", vlog.size(), 4);
        if (vlog.size() == 4) begin
            chk("t2_v0", vlog[0], {1'b0, 8'h11});
            chk("t2_v1", vlog[1], {1'b1, 8'h44});
            chk("t2_v2", vlog[2], {1'b0, 8'h11});
            chk("t2_v3", vlog[3], {1'b1, 8'h44});
        end

        // Requester 1 alone, addresses 0..3 back to back.
        vlog.delete();
        for (int a = 0; a < 4; a++) begin
            addr1[0] = 2'(a);
            req1[0]  = 1'b1;
            wait_gnt1(0, n, ok);
            chk($sformatf("t3_gnt_wait_a%0d", a), ok, 1);
        end
        req1[0] = 1'b0;
        drain(6);
        chk("t3_nvalid", vlog.size(), 4);
        if (vlog.size() == 4) begin
            chk("t3_v0", vlog[0], {1'b1, 8'h11});
            chk("t3_v1", vlog[1], {1'b1, 8'h22});
            chk("t3_v2", vlog[2], {1'b1, 8'h33});
            chk("t3_v3", vlog[3], {1'b1, 8'h44});
        end

        // MEM_LAT=3 instance: requester 1, address 1.
        req1[1] = 1'b1; addr1[1] = 2'd1;
        @(negedge clk);
        req1[1] = 1'b0;
        nb = 0; vc = -1; vd = 8'h00;
        while (busy[1] && nb < 10) begin
            if (val1[1]) begin
                vc = nb;
                vd = data[1];
            end
            nb = nb + 1;
            @(negedge clk);
        end
        chk("t4_busy_cycles", nb, 5);
        chk("t4_valid_cycle", vc, 4);
        chk("t4_data", vd, 8'h22);

        // Reset during WAIT drops the read and restores requester-0 priority.
        vlog.delete();
        req0[0] = 1'b1; addr0[0] = 2'd1;
        @(negedge clk);
        req0[0] = 1'b0;
        @(negedge clk);
        chk("t5_in_wait_busy", busy[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_after_reset", {gnt0[0], gnt1[0], val0[0], val1[0], men[0], busy[0], maddr[0], data[0]}, 0);
        req0[0] = 1'b1; addr0[0] = 2'd3; req1[0] = 1'b1; addr1[0] = 2'd0;
        @(negedge clk);
        chk("t5_first_gnt0", gnt0[0], 1);
        chk("t5_first_gnt1", gnt1[0], 0);
        req0[0] = 1'b0;
        wait_gnt1(0, n, ok);
        chk("t5_loser_gnt_wait", ok, 1);
        chk("t5_loser_gnt_delay", n, 4);
        req1[0] = 1'b0;
        drain(6);
        chk("t5_nvalid", vlog.size(), 2);
        if (vlog.size() == 2) begin
            chk("t5_v0", vlog[0], {1'b0, 8'h44});
            chk("t5_v1", vlog[1], {1'b1, 8'h11});
        end

        // Requester 1 arrives during ISSUE of a requester-0 read.
        req0[0] = 1'b1; addr0[0] = 2'd2;
        @(negedge clk);
        req0[0] = 1'b0;
        req1[0] = 1'b1; addr1[0] = 2'd1;
        wait_gnt1(0, n, ok);
        chk("t6_gnt_wait", ok, 1);
        chk("t6_gnt1_delay", n, 4);
        req1[0] = 1'b0;
        drain(6);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Two-port round-robin arbiter that shares one synchronous-read memory (4x8 lookup ROM class, registered output) between two requesters.
- Serialises read requests, drives the memory address and enable, waits the memory latency, then returns the data to the winning requester with a one-cycle valid pulse.
- Sits between the ROM instance and its consumers, replacing free-running counter addressing wherever more than one block needs table access.

Parameters:
- ADDR_W, 2, memory address width.
- DATA_W, 8, memory data width.
- MEM_LAT, 1, cycles from the edge that samples oMemEn/oMemAddr until iMemData is valid. Legal range is 1..4.

Ports:
- iClk  in  1  clock, rising edge.
- iReset  in  1  synchronous reset, active-high.
- iReq0  in  1  read request, requester 0.
- iAddr0  in  ADDR_W  read address, requester 0.
- iReq1  in  1  read request, requester 1.
- iAddr1  in  ADDR_W  read address, requester 1.
- oGnt0  out  1  one-cycle grant pulse, requester 0.
- oGnt1  out  1  one-cycle grant pulse, requester 1.
- oValid0  out  1  one-cycle read-data-valid pulse, requester 0.
- oValid1  out  1  one-cycle read-data-valid pulse, requester 1.
- oData  out  DATA_W  read data, shared by both requesters and qualified by oValidN.
- oMemAddr  out  ADDR_W  memory address.
- oMemEn  out  1  memory read enable.
- iMemData  in  DATA_W  memory read data.
- oBusy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, iClk. iReset is synchronous and active-high. All state is updated on the rising edge of iClk.
- Reset values:
  - State = IDLE.
  - oGnt0/1, oValid0/1, oMemEn, oBusy = 0.
  - oData = 0, oMemAddr = 0.
  - Round-robin pointer rLast = 1, so requester 0 has first priority.
- FSM states are IDLE, ISSUE, WAIT and RESP. All outputs are registered or decoded from state only; there is no combinational path from iReq to any output.
- IDLE:
  - At each edge, if iReq0 or iReq1 is high, select a winner.
  - A single requester always wins.
  - If both are requesting, the winner is the requester that is not rLast.
  - On that edge: latch the winner's address into rAddr, latch the winner ID, set rLast = winner, and go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - oMemEn = 1, oMemAddr = rAddr, oGntN = 1 for the winner.
  - Load the latency counter with MEM_LAT-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the edge where the counter is 0: oData <= iMemData, go to RESP.
  - WAIT therefore lasts MEM_LAT cycles.
- RESP (exactly 1 cycle):
  - oValidN = 1 for the winner; oData holds the captured value.
  - Next state is IDLE. No arbitration happens on the RESP edge.
- Latency and throughput:
  - Request-sampling edge E0: oGnt/oMemEn high in cycle E0..E1.
  - Data captured at edge E(1+MEM_LAT); oValid high for the following cycle.
  - One access every 3+MEM_LAT cycles, i.e. 4 cycles with MEM_LAT=1.
- Output holding:
  - oData holds its last captured value until the next capture.
  - oMemAddr holds rAddr outside ISSUE; oMemEn = 0 outside ISSUE.
- Requester protocol:
  - Hold iReqN and iAddrN stable until oGntN is seen; the address is consumed at the sampling edge.
  - Deassert iReqN in the cycle oGntN is high, unless another read is wanted.
  - If iReqN is still high when the FSM returns to IDLE, it is treated as a new request.
- Boundary cases:
  - Address wrap: none; the address is passed through unchanged. Address 2^ADDR_W-1 is legal.
  - Requests arriving while oBusy=1 are ignored until IDLE. No queueing beyond holding iReq.
  - Simultaneous requests in IDLE alternate strictly: 0,1,0,1...
  - The loser keeps waiting with iReq high and wins the next arbitration.
  - Reset asserted in any state returns to reset values on that edge. An in-flight read is dropped: no oValid, and no late oData update.
  - Reset has priority over every other event on the same edge.

Test Plan:
- Memory model holds 0x11, 0x22, 0x33, 0x44 at addresses 0..3, MEM_LAT=1. iReq0=1, iAddr0=2 for one cycle from IDLE -> oGnt0 and oMemEn high 1 cycle later with oMemAddr=2; oValid0=1 and oData=0x33 3 cycles after the sampling edge; oGnt1/oValid1 stay 0.
- iReq0 and iReq1 held high continuously with iAddr0=0, iAddr1=3 -> grants alternate 0,1,0,1 starting with 0, every 4 cycles; oData alternates 0x11, 0x44 with the matching oValidN.
- Requester 1 alone, addresses 0..3 back-to-back -> oData sequence 0x11, 0x22, 0x33, 0x44, oValid1 every 4 cycles; the iAddr1=3 access returns 0x44 without error.
- MEM_LAT=3, iReq1 with iAddr1=1 -> oValid1 5 cycles after the sampling edge, oData=0x22; oBusy high for 5 cycles.
- iReset pulsed during WAIT -> next cycle all outputs 0 and state IDLE; no oValid for the dropped read. The first subsequent dual request grants requester 0.
- iReq1 raised during ISSUE of a requester-0 access -> ignored until IDLE, then granted; oGnt1 appears 1 cycle after the IDLE sampling edge.
